lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Sequences the load/store/call/ret operations that the execute stage flags but does not perform.
- Owns the single data-memory port through a req/ack handshake, and the hardware stack pointer used by call/ret.
- Writes back load results, returns the popped PC for ret, and stalls the pipeline while an access is outstanding.

Parameters:
- DATA_W, 32, width of data, address and PC values.
- SP_INIT, 32'h0000_FFFC, reset/empty value of the stack pointer (word aligned).
- SP_LIMIT, 32'h0000_F000, lowest legal stack slot address; a push below it is an overflow.
- TIMEOUT, 64, cycles to wait for mem_ack (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  execute stage presents an op this cycle.
- issue_ready  out  1  controller accepts the op (high only in IDLE).
- is_ld_op, is_str_op, is_call_op, is_ret_op  in  1 each  op flags from execute.
- addr  in  DATA_W  effective address for ld/str (execute's mem_passthrough).
- st_data  in  DATA_W  store data (rd_val_passthrough).
- rd_num  in  4  load destination register.
- ret_pc  in  DATA_W  return address pushed by call.
- flush  in  1  squash the pending writeback/redirect.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory completes the request on this edge.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- wb_en  out  1  one-cycle register-write pulse.
- wb_num  out  4  writeback register.
- wb_val  out  DATA_W  writeback value.
- pc_load  out  1  one-cycle PC redirect pulse (ret).
- pc_val  out  DATA_W  popped return address.
- stall  out  1  freeze upstream stages.
- sp  out  DATA_W  current stack pointer.
- err  out  1  one-cycle pulse on stack overflow/underflow (or timeout).

Behaviour:
- Reset: state=IDLE, sp=SP_INIT. mem_req, mem_we, wb_en, pc_load and err are 0. All data outputs are 0.
- States: IDLE, REQ, RESP.
- IDLE: issue_ready=1, stall=0.
  - issue_valid with any op flag set: latch the op, address, data and rd_num; go to REQ.
  - Flag priority when several are set: ret > call > str > ld.
  - issue_valid with no flag set: ignored.
- Per-op access:
  - ld: read from addr.
  - str: write st_data to addr.
  - call: write ret_pc to sp-4.
  - ret: read from sp.
- Stack errors:
  - call with sp-4 < SP_LIMIT is an overflow.
  - ret with sp == SP_INIT is an underflow.
  - On either, skip the memory access, pulse err the next cycle, and return to IDLE. sp is unchanged.
- REQ: mem_req=1 and stall=1. Address and data outputs stay stable until the ack edge.
  - On mem_ack: capture mem_rdata and go to RESP.
  - On mem_ack, call sets sp<=sp-4 and ret sets sp<=sp+4.
- RESP (exactly one cycle): stall=1, mem_req=0, then return to IDLE.
  - ld: wb_en=1, wb_num=rd_num, wb_val=captured data.
  - ret: pc_load=1, pc_val=captured data.
  - str/call: no pulse.
- Latency: minimum 3 cycles from accept to the IDLE re-accept (accept, REQ with same-cycle ack, RESP). No back-to-back overlap.
- flush:
  - Asserted in REQ or RESP: the wb_en/pc_load pulse is suppressed.
  - The memory transaction still completes, because the memory cannot be aborted.
  - The sp update still occurs.
  - flush in IDLE is ignored.
- Reset mid-operation: mem_req drops asynchronously and sp returns to SP_INIT. The memory side must tolerate an abandoned request.
- sp arithmetic is modulo 2^DATA_W. Bits [1:0] of sp are always 0.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter runs in REQ.
  - After TIMEOUT cycles without mem_ack: drop mem_req, pulse err, return to IDLE with no writeback and no sp change.
  - A late ack arriving in IDLE is ignored.
- LSU_TIMEOUT_EN undefined: REQ waits indefinitely and no counter logic exists.

Decomposition:
- Shared package (lsu_pkg): state encoding constants (IDLE/REQ/RESP), op-kind encoding (OP_LD/OP_ST/OP_CALL/OP_RET), and SP_INIT/SP_LIMIT defaults.
- One sub-module, lsu_stack_ptr:
  - holds sp;
  - provides push/pop commit inputs;
  - computes overflow/underflow combinationally.
- The FSM stays in lsu_ctrl.

Test Plan:
- ld addr=0x100, rd_num=3, ack after 2 REQ cycles with rdata=0xDEADBEEF -> one wb_en pulse, wb_num=3, wb_val=0xDEADBEEF; stall high for 4 cycles.
- str addr=0x200, st_data=0x1234, same-cycle ack -> mem_we=1, mem_addr=0x200, mem_wdata=0x1234; no wb_en; idle after 3 cycles.
- call ret_pc=0x40, then ret returning rdata=0x40 -> call writes 0xFFF8 with sp becoming 0xFFF8; ret reads 0xFFF8, pc_load=1, pc_val=0x40, sp back to 0xFFFC.
- ret from reset (sp=0xFFFC) -> err pulse, mem_req never asserted, pc_load=0, sp unchanged. Repeated calls until sp=0xF000, then one more call -> err pulse, sp stays 0xF000.
- ld with flush asserted in REQ, ack later -> mem_req handshake completes, wb_en stays 0. rst_n low mid-REQ -> mem_req=0 immediately, sp=0xFFFC.
- With LSU_TIMEOUT_EN and TIMEOUT=64: ld with no ack -> mem_req drops after 64 cycles, err pulses, issue_ready=1 the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared encodings and defaults for the load/store/stack unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int unsigned DATA_W_DEFAULT   = 32;
    localparam logic [31:0] SP_INIT_DEFAULT  = 32'h0000_FFFC;
    localparam logic [31:0] SP_LIMIT_DEFAULT = 32'h0000_F000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        OP_LD   = 2'd0,
        OP_ST   = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } lsu_op_t;

    function automatic logic op_is_write(input lsu_op_t op);
        return (op == OP_ST) || (op == OP_CALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl_if
//  Brief    : Single data-memory port, req/ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_stack_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_stack_ptr
//  Brief    : Hardware stack pointer with push/pop commit strobes and
//             combinational overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_stack_ptr
    import lsu_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] SP_INIT  = SP_INIT_DEFAULT,
    parameter logic [DATA_W-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push,
    input  wire logic              pop,
    output logic [DATA_W-1:0]      sp,
    output logic [DATA_W-1:0]      push_addr,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [DATA_W-1:0] c_WORD_BYTES = DATA_W'(4);

    logic [DATA_W-1:0] r_sp;

    // Wrap-around is intentional: sp arithmetic is modulo 2^DATA_W.
    assign push_addr = r_sp - c_WORD_BYTES;
    assign overflow  = (push_addr < SP_LIMIT);
    assign underflow = (r_sp == SP_INIT);
    assign sp        = r_sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= SP_INIT;
        end else if (push) begin
            r_sp <= push_addr;
        end else if (pop) begin
            r_sp <= r_sp + c_WORD_BYTES;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Brief    : Sequences ld/str/call/ret over one req/ack memory port, owns the
//             stack pointer. Optional macro LSU_TIMEOUT_EN adds an ack timeout.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] SP_INIT  = SP_INIT_DEFAULT,
    parameter logic [DATA_W-1:0] SP_LIMIT = SP_LIMIT_DEFAULT
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int                TIMEOUT  = 64
`endif
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              issue_valid,
    output logic                   issue_ready,
    input  wire logic              is_ld_op,
    input  wire logic              is_str_op,
    input  wire logic              is_call_op,
    input  wire logic              is_ret_op,
    input  wire logic [DATA_W-1:0] addr,
    input  wire logic [DATA_W-1:0] st_data,
    input  wire logic [3:0]        rd_num,
    input  wire logic [DATA_W-1:0] ret_pc,
    input  wire logic              flush,
    lsu_ctrl_if.master             mem,
    output logic                   wb_en,
    output logic [3:0]             wb_num,
    output logic [DATA_W-1:0]      wb_val,
    output logic                   pc_load,
    output logic [DATA_W-1:0]      pc_val,
    output logic                   stall,
    output logic [DATA_W-1:0]      sp,
    output logic                   err
);

    lsu_state_t        r_state;
    lsu_op_t           r_op;
    logic [3:0]        r_rd_num;
    logic              r_flushed;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wb_en;
    logic [3:0]        r_wb_num;
    logic [DATA_W-1:0] r_wb_val;
    logic              r_pc_load;
    logic [DATA_W-1:0] r_pc_val;
    logic              r_err;

    lsu_op_t           w_op;
    logic              w_any_op;
    logic              w_stack_err;
    logic              w_ack_edge;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_push_addr;
    logic              w_overflow;
    logic              w_underflow;

`ifdef LSU_TIMEOUT_EN
    localparam int             c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    logic [c_TMO_W-1:0]        r_tmo_cnt;
`endif

    // Later assignments win, giving ret > call > str > ld.
    always_comb begin
        w_op = OP_LD;
        if (is_str_op)  w_op = OP_ST;
        if (is_call_op) w_op = OP_CALL;
        if (is_ret_op)  w_op = OP_RET;
    end

    assign w_any_op    = is_ld_op | is_str_op | is_call_op | is_ret_op;
    assign w_stack_err = ((w_op == OP_CALL) && w_overflow) ||
                         ((w_op == OP_RET)  && w_underflow);
    assign w_ack_edge  = (r_state == REQ) && mem.mem_ack;
    assign w_push      = w_ack_edge && (r_op == OP_CALL);
    assign w_pop       = w_ack_edge && (r_op == OP_RET);

    lsu_stack_ptr #(
        .DATA_W   (DATA_W),
        .SP_INIT  (SP_INIT),
        .SP_LIMIT (SP_LIMIT)
    ) u_stack_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .sp        (sp),
        .push_addr (w_push_addr),
        .overflow  (w_overflow),
        .underflow (w_underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_LD;
            r_rd_num    <= '0;
            r_flushed   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_en     <= 1'b0;
            r_wb_num    <= '0;
            r_wb_val    <= '0;
            r_pc_load   <= 1'b0;
            r_pc_val    <= '0;
            r_err       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            r_wb_en   <= 1'b0;
            r_pc_load <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (issue_valid && w_any_op) begin
                        r_op      <= w_op;
                        r_rd_num  <= rd_num;
                        r_flushed <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if (w_stack_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= op_is_write(w_op);
                            r_mem_addr  <= (w_op == OP_CALL) ? w_push_addr :
                                           (w_op == OP_RET)  ? sp : addr;
                            r_mem_wdata <= (w_op == OP_CALL) ? ret_pc : st_data;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        // A flush seen anywhere in REQ cancels the pulse; the access itself still completes.
                        if (!(flush || r_flushed)) begin
                            if (r_op == OP_LD) begin
                                r_wb_en  <= 1'b1;
                                r_wb_num <= r_rd_num;
                                r_wb_val <= mem.mem_rdata;
                            end
                            if (r_op == OP_RET) begin
                                r_pc_load <= 1'b1;
                                r_pc_val  <= mem.mem_rdata;
                            end
                        end
                    end else begin
                        if (flush) r_flushed <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                        if (r_tmo_cnt == c_TMO_LAST) begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                            r_mem_we  <= 1'b0;
                            r_err     <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                        end
`endif
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign issue_ready   = (r_state == IDLE);
    assign stall         = (r_state != IDLE);
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    // flush during RESP must still be able to kill the pulse in that cycle.
    assign wb_en         = r_wb_en & ~flush;
    assign wb_num        = r_wb_num;
    assign wb_val        = r_wb_val;
    assign pc_load       = r_pc_load & ~flush;
    assign pc_val        = r_pc_val;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Brief    : Directed, table-driven self-checking bench for lsu_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        is_ld_op = 1'b0, is_str_op = 1'b0, is_call_op = 1'b0, is_ret_op = 1'b0;
    logic [31:0] addr = '0, st_data = '0, ret_pc = '0;
    logic [3:0]  rd_num = '0;
    logic        flush = 1'b0;
    logic        wb_en, pc_load, stall, err;
    logic [3:0]  wb_num;
    logic [31:0] wb_val, pc_val, sp;

    lsu_ctrl_if #(.DATA_W(32)) mem_bus ();

    lsu_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .is_ld_op(is_ld_op), .is_str_op(is_str_op),
        .is_call_op(is_call_op), .is_ret_op(is_ret_op),
        .addr(addr), .st_data(st_data), .rd_num(rd_num), .ret_pc(ret_pc),
        .flush(flush), .mem(mem_bus),
        .wb_en(wb_en), .wb_num(wb_num), .wb_val(wb_val),
        .pc_load(pc_load), .pc_val(pc_val),
        .stall(stall), .sp(sp), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;      // {ret, call, str, ld}
        logic [31:0] addr, st_data;
        logic [3:0]  rd_num;
        logic [31:0] ret_pc;
        int          ack_delay;  // REQ cycles before the ack cycle
        logic [31:0] rdata;
        int          flush_mode; // 0 none, 1 first REQ cycle, 2 accept cycle
        bit          e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        bit          e_wb;
        logic [3:0]  e_wb_num;
        logic [31:0] e_wb_val;
        bit          e_pc;
        logic [31:0] e_pc_val;
        bit          e_err;
        logic [31:0] e_sp;
        int          e_stall;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    int          o_req, o_wb, o_pc, o_err, o_stall;
    bit          o_done, o_unstable;
    logic        o_we;
    logic [31:0] o_addr, o_wdata, o_wb_val, o_pc_val;
    logic [3:0]  o_wb_num;

    function automatic vec_t mk(
        input logic [3:0] f, input logic [31:0] a, input logic [31:0] d, input logic [3:0] rn,
        input logic [31:0] rp, input int dly, input logic [31:0] rd, input int fm,
        input bit er, input bit ew, input logic [31:0] ea, input logic [31:0] ewd,
        input bit ewb, input logic [3:0] ewn, input logic [31:0] ewv,
        input bit epc, input logic [31:0] epv, input bit eerr, input logic [31:0] esp, input int est);
        vec_t v;
        v.flags = f; v.addr = a; v.st_data = d; v.rd_num = rn; v.ret_pc = rp;
        v.ack_delay = dly; v.rdata = rd; v.flush_mode = fm;
        v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd;
        v.e_wb = ewb; v.e_wb_num = ewn; v.e_wb_val = ewv;
        v.e_pc = epc; v.e_pc_val = epv; v.e_err = eerr; v.e_sp = esp; v.e_stall = est;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge idle.
    task automatic run_op(input vec_t v);
        o_req = 0; o_wb = 0; o_pc = 0; o_err = 0; o_stall = 0;
        o_done = 1'b0; o_unstable = 1'b0;
        o_we = 1'b0; o_addr = '0; o_wdata = '0; o_wb_val = '0; o_pc_val = '0; o_wb_num = '0;
        issue_valid = 1'b1;
        {is_ret_op, is_call_op, is_str_op, is_ld_op} = v.flags;
        addr = v.addr; st_data = v.st_data; rd_num = v.rd_num; ret_pc = v.ret_pc;
        flush = (v.flush_mode == 2);
        @(negedge clk);
        issue_valid = 1'b0;
        {is_ret_op, is_call_op, is_str_op, is_ld_op} = 4'b0000;
        for (int cyc = 0; cyc < 300; cyc++) begin
            mem_bus.mem_ack = 1'b0;
            flush = 1'b0;
            if (stall) o_stall++;
            if (err) o_err++;
            if (wb_en) begin o_wb++; o_wb_num = wb_num; o_wb_val = wb_val; end
            if (pc_load) begin o_pc++; o_pc_val = pc_val; end
            if (mem_bus.mem_req) begin
                if (o_req == 0) begin
                    o_we = mem_bus.mem_we; o_addr = mem_bus.mem_addr; o_wdata = mem_bus.mem_wdata;
                    if (v.flush_mode == 1) flush = 1'b1;
                end else if (mem_bus.mem_addr !== o_addr || mem_bus.mem_wdata !== o_wdata ||
                             mem_bus.mem_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                if (o_req == v.ack_delay) begin
                    mem_bus.mem_ack = 1'b1;
                    mem_bus.mem_rdata = v.rdata;
                end
                o_req++;
            end
            if (!stall) begin
                o_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        mem_bus.mem_ack = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("finished", i, 32'(o_done), 32'd1);
        chk("req_seen", i, 32'(o_req > 0), 32'(v.e_req));
        if (v.e_req) begin
            chk("mem_we",    i, 32'(o_we), 32'(v.e_we));
            chk("mem_addr",  i, o_addr, v.e_addr);
            if (v.e_we) chk("mem_wdata", i, o_wdata, v.e_wdata);
            chk("req_stable", i, 32'(o_unstable), 32'd0);
        end
        chk("wb_count", i, 32'(o_wb), 32'(v.e_wb));
        if (v.e_wb) begin
            chk("wb_num", i, 32'(o_wb_num), 32'(v.e_wb_num));
            chk("wb_val", i, o_wb_val, v.e_wb_val);
        end
        chk("pc_count", i, 32'(o_pc), 32'(v.e_pc));
        if (v.e_pc) chk("pc_val", i, o_pc_val, v.e_pc_val);
        chk("err_count", i, 32'(o_err), 32'(v.e_err));
        chk("stall_cycles", i, 32'(o_stall), 32'(v.e_stall));
        chk("sp_after", i, sp, v.e_sp);
    endtask

    vec_t vecs[13];

    initial begin
        vec_t cv;
        int   err_sum;

        vecs[0]  = mk(4'b0001, 32'h100, 32'h0, 4'd3, 32'h0, 2, 32'hDEAD_BEEF, 0,
                      1, 0, 32'h100, 32'h0, 1, 4'd3, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'hFFFC, 4);
        vecs[1]  = mk(4'b0010, 32'h200, 32'h1234, 4'd0, 32'h0, 0, 32'h0, 0,
                      1, 1, 32'h200, 32'h1234, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFFC, 2);
        vecs[2]  = mk(4'b1000, 32'h0, 32'h0, 4'd0, 32'h0, 0, 32'h77, 0,
                      0, 0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hFFFC, 0);
        vecs[3]  = mk(4'b0100, 32'h500, 32'h11, 4'd0, 32'h40, 1, 32'h0, 0,
                      1, 1, 32'hFFF8, 32'h40, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFF8, 3);
        vecs[4]  = mk(4'b1000, 32'h600, 32'h0, 4'd0, 32'h0, 0, 32'h40, 0,
                      1, 0, 32'hFFF8, 32'h0, 0, 4'd0, 32'h0, 1, 32'h40, 0, 32'hFFFC, 2);
        vecs[5]  = mk(4'b0001, 32'h104, 32'h0, 4'd5, 32'h0, 3, 32'h5555, 1,
                      1, 0, 32'h104, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFFC, 5);
        vecs[6]  = mk(4'b0001, 32'h108, 32'h0, 4'd7, 32'h0, 1, 32'hCAFE, 2,
                      1, 0, 32'h108, 32'h0, 1, 4'd7, 32'hCAFE, 0, 32'h0, 0, 32'hFFFC, 3);
        vecs[7]  = mk(4'b1111, 32'h300, 32'h99, 4'd1, 32'h80, 0, 32'h0, 0,
                      0, 0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hFFFC, 0);
        vecs[8]  = mk(4'b0111, 32'h300, 32'h99, 4'd1, 32'h80, 0, 32'h0, 0,
                      1, 1, 32'hFFF8, 32'h80, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFF8, 2);
        vecs[9]  = mk(4'b0011, 32'h400, 32'hABCD, 4'd2, 32'h0, 0, 32'h1, 0,
                      1, 1, 32'h400, 32'hABCD, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFF8, 2);
        vecs[10] = mk(4'b1000, 32'h0, 32'h0, 4'd0, 32'h0, 2, 32'h80, 0,
                      1, 0, 32'hFFF8, 32'h0, 0, 4'd0, 32'h0, 1, 32'h80, 0, 32'hFFFC, 4);
        vecs[11] = mk(4'b0000, 32'h700, 32'h0, 4'd0, 32'h0, 0, 32'h0, 0,
                      0, 0, 32'h0, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 0, 32'hFFFC, 0);
        vecs[12] = mk(4'b0001, 32'hFFC, 32'h0, 4'd15, 32'h0, 0, 32'h0123_4567, 0,
                      1, 0, 32'hFFC, 32'h0, 1, 4'd15, 32'h0123_4567, 0, 32'h0, 0, 32'hFFFC, 2);

        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        #12;
        chk("rst_mem_req", 0, 32'(mem_bus.mem_req), 32'd0);
        chk("rst_sp",      0, sp, 32'hFFFC);
        chk("rst_ready",   0, 32'(issue_ready), 32'd1);
        chk("rst_outs",    0, 32'({wb_en, pc_load, err, stall, mem_bus.mem_we}), 32'd0);
        chk("rst_data",    0, wb_val | pc_val | mem_bus.mem_addr | mem_bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            chk("ready_before", i, 32'(issue_ready), 32'd1);
            run_op(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Fill the stack down to the limit, then one call too many.
        cv = mk(4'b0100, 32'h0, 32'h0, 4'd0, 32'h1234, 0, 32'h0, 0,
                1, 1, 32'h0, 32'h1234, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hF000, 0);
        err_sum = 0;
        for (int k = 0; k < 1023; k++) begin
            run_op(cv);
            err_sum += o_err;
        end
        chk("fill_errs", 100, 32'(err_sum), 32'd0);
        chk("fill_sp",   100, sp, 32'hF000);
        cv.e_req = 1'b0; cv.e_stall = 0;
        run_op(cv);
        check_vec(101, cv);

`ifdef LSU_TIMEOUT_EN
        cv = mk(4'b0001, 32'h800, 32'h0, 4'd4, 32'h0, 1000, 32'h0, 0,
                1, 0, 32'h800, 32'h0, 0, 4'd0, 32'h0, 0, 32'h0, 1, 32'hF000, 64);
        run_op(cv);
        check_vec(102, cv);
        chk("tmo_req_cycles", 102, 32'(o_req), 32'd64);
        chk("tmo_ready", 102, 32'(issue_ready), 32'd1);
`endif

        // Reset in the middle of a request.
        issue_valid = 1'b1; is_ld_op = 1'b1; addr = 32'h900;
        @(negedge clk);
        issue_valid = 1'b0; is_ld_op = 1'b0;
        chk("mid_req_active", 103, 32'(mem_bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 103, 32'(mem_bus.mem_req), 32'd0);
        chk("mid_rst_sp",      103, sp, 32'hFFFC);
        chk("mid_rst_ready",   103, 32'(issue_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 104, 32'({mem_bus.mem_req, stall}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
